mant_mul_pipe: RTL

Parametrised, pipelined unsigned mantissa multiplier for the FPU multiply path. It forms MW partial-product rows and reduces them pairwise in a binary adder tree, with a register stage after every LPS tree levels. A valid/ready handshake carries a sideband tag through the pipe. Backpressure stalls only the stages that cannot advance, so bubbles are squeezed out. It generalises the fixed 24-bit, purely combinational second-level row combiner into a width-configurable, throughput-one, stallable pipeline.

---
 rtl/mant_mul_pipe_pkg.sv | 30 +++
 rtl/mant_mul_level.sv | 25 ++
 rtl/mant_mul_pipe.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mant_mul_pipe_pkg.sv
// Shared FPU multiply-path constants and elaboration helpers.
package mant_mul_pipe_pkg;

   localparam int MW_SP = 24;
   localparam int MW_DP = 53;

   // Adder-tree depth for mw partial-product rows: ceil(log2(mw)).
   function automatic int tree_depth(input int mw);
      int d;
      d = 0;
      while ((1 << d) < mw) d++;
      return d;
   endfunction

   // Register stages: the operand stage plus one per group of lps tree levels.
   function automatic int stage_count(input int mw, input int lps);
      int l;
      l = tree_depth(mw);
      return 1 + (l + lps - 1) / lps;
   endfunction

   // Number of rows entering tree level lvl (level 0 sees all mw rows).
   function automatic int rows_at(input int mw, input int lvl);
      int n;
      n = mw;
      for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
      return n;
   endfunction

endpackage

// File: rtl/mant_mul_level.sv
// One adder-tree level: sums rows in adjacent pairs, an odd last row passes through.
module mant_mul_level
   import mant_mul_pipe_pkg::*;
#(
   parameter int W = 48,
   parameter int N = 24
) (
   input  logic [N*W-1:0]         rows_in,
   output logic [((N+1)/2)*W-1:0] rows_out
);

   localparam int NO = (N + 1) / 2;

   // Pairwise row addition; sums wrap at W bits, which never loses a carry of the product.
   always_comb begin
      rows_out = '0;
      for (int i = 0; i < N / 2; i++) begin
         rows_out[i*W +: W] = rows_in[2*i*W +: W] + rows_in[(2*i+1)*W +: W];
      end
      if (N % 2 == 1) begin
         rows_out[(NO-1)*W +: W] = rows_in[(N-1)*W +: W];
      end
   end

endmodule

// File: rtl/mant_mul_pipe.sv
// Pipelined unsigned mantissa multiplier: partial-product rows reduced by a
// binary adder tree, registered every LPS levels, with a stallable valid/ready chain.
module mant_mul_pipe
   import mant_mul_pipe_pkg::*;
#(
   parameter int MW    = MW_SP,
   parameter int LPS   = 2,
   parameter int TAG_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MW-1:0]     in_a,
   input  logic [MW-1:0]     in_b,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*MW-1:0]   out_prod,
   output logic              out_sticky,
   output logic [TAG_W-1:0]  out_tag
);

   localparam int W = 2 * MW;
   localparam int L = tree_depth(MW);
   localparam int S = stage_count(MW, LPS);

   logic [S-1:0]       v;
   logic [S-1:0]       ld;
   logic [MW-1:0]      a_q;
   logic [MW-1:0]      b_q;
   logic [TAG_W-1:0]   tag_q [S];
   logic [MW*W-1:0]    pp;
   logic [W-1:0]       prod_c;

   // Stage k loads when empty or when its consumer takes its content; ready ripples back from out_ready.
   always_comb begin
      logic chain;
      chain = out_ready;
      ld    = '0;
      for (int k = S - 1; k >= 0; k--) begin
         chain = !v[k] || chain;
         ld[k] = chain;
      end
   end

   assign in_ready  = ld[0];
   assign out_valid = v[S-1];
   assign out_tag   = tag_q[S-1];

   // Valid chain; a loading stage inherits its upstream valid, so bubbles collapse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v <= '0;
      end else begin
         if (ld[0]) v[0] <= in_valid;
         for (int k = 1; k < S; k++) begin
            if (ld[k]) v[k] <= v[k-1];
         end
      end
   end

   // Operand stage and tag pipeline; registers only move on real data so held outputs stay stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         for (int k = 0; k < S; k++) tag_q[k] <= '0;
      end else begin
         if (in_valid && ld[0]) begin
            a_q      <= in_a;
            b_q      <= in_b;
            tag_q[0] <= in_tag;
         end
         for (int k = 1; k < S; k++) begin
            if (ld[k] && v[k-1]) tag_q[k] <= tag_q[k-1];
         end
      end
   end

   // Partial-product rows: row i is a masked by b[i], shifted left by i.
   always_comb begin
      pp = '0;
      for (int i = 0; i < MW; i++) begin
         pp[i*W +: W] = W'(a_q & {MW{b_q[i]}}) << i;
      end
   end

   for (genvar j = 0; j < L; j++) begin : g_lvl
      localparam int NI = rows_at(MW, j);
      localparam int NO = rows_at(MW, j + 1);
      logic [NI*W-1:0] src;
      logic [NO*W-1:0] sum;

      if (j == 0) begin : g_first
         assign src = pp;
      end else if (j % LPS == 0) begin : g_reg
         // Pipeline register in front of this level, owned by stage j/LPS.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               src <= '0;
            end else if (ld[j/LPS] && v[j/LPS-1]) begin
               src <= g_lvl[j-1].sum;
            end
         end
      end else begin : g_comb
         assign src = g_lvl[j-1].sum;
      end

      mant_mul_level #(.W(W), .N(NI)) u_level (
         .rows_in  (src),
         .rows_out (sum)
      );
   end

   assign prod_c = g_lvl[L-1].sum;

   // Result stage: product and sticky (bits below the guard of an MW-bit normalised result).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_prod   <= '0;
         out_sticky <= 1'b0;
      end else if (ld[S-1] && v[S-2]) begin
         out_prod   <= prod_c;
         out_sticky <= |prod_c[MW-2:0];
      end
   end

endmodule
